// File: rtl/prof_pkg.sv
// Shared definitions for the cycle profiler slice.
//   CNT_W_DEF / DEPTH_DEF : default measurement width and result FIFO depth
//   N_MEAS_W              : width of the saturating measurement counter
//   state_t               : profiler FSM state encoding
package prof_pkg;

  localparam int unsigned CNT_W_DEF = 32;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned N_MEAS_W  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/prof_fifo.sv
// Synchronous show-ahead FIFO for completed measurements.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous flush (empties the FIFO)
//   push/din : write request and data; accepted when not full, or when a pop
//              in the same cycle frees the head slot
//   pop      : read request; ignored while empty
//   dout     : head entry (zero while empty)
//   empty/full
module prof_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra MSB on each pointer distinguishes full from empty when the
  // index bits coincide.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/cycle_profiler.sv
// Measures elapsed cycles between start/stop pulses using an external
// free-running cycle count, buffering results in a small FIFO.
//   clk, rst            : clock, asynchronous active-high reset
//   cycle_cnt           : free-running cycle count (may wrap)
//   start, stop         : single-cycle interval markers
//   clr                 : synchronous clear of FIFO, overflow, n_meas, FSM
//   res_valid/res_data  : FIFO head, show-ahead; res_ready pops it
//   busy                : interval in progress
//   overflow            : sticky, a result was dropped on a full FIFO
//   n_meas              : saturating count of completed measurements
module cycle_profiler
  import prof_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned PTR_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CNT_W-1:0]    cycle_cnt,
  input  logic                start,
  input  logic                stop,
  input  logic                clr,
  output logic                res_valid,
  output logic [CNT_W-1:0]    res_data,
  input  logic                res_ready,
  output logic                busy,
  output logic                overflow,
  output logic [N_MEAS_W-1:0] n_meas
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] t_start, t_start_nxt;
  logic [CNT_W-1:0] elapsed;
  logic             do_push;
  logic             do_pop;
  logic             fifo_empty;
  logic             fifo_full;

  // Modulo subtraction gives the right interval across counter wrap.
  assign elapsed = cycle_cnt - t_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      t_start <= '0;
    end else begin
      state   <= state_nxt;
      t_start <= t_start_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    t_start_nxt = t_start;
    do_push     = 1'b0;
    if (clr) begin
      state_nxt   = IDLE;
      t_start_nxt = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            t_start_nxt = cycle_cnt;
            state_nxt   = RUN;
          end
        end
        RUN: begin
          // start together with stop closes this interval and opens the next
          if (stop) begin
            do_push = 1'b1;
            if (!start) state_nxt = IDLE;
          end
          if (start) t_start_nxt = cycle_cnt;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign res_valid = !fifo_empty;
  assign do_pop    = res_valid && res_ready;
  assign busy      = (state == RUN);

  prof_fifo #(
    .WIDTH (CNT_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (do_push),
    .din   (elapsed),
    .pop   (do_pop),
    .dout  (res_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      n_meas   <= '0;
    end else if (clr) begin
      overflow <= 1'b0;
      n_meas   <= '0;
    end else if (do_push) begin
      // a simultaneous pop frees the slot, so only a true full drops
      if (fifo_full && !do_pop) overflow <= 1'b1;
      if (n_meas != '1) n_meas <= n_meas + N_MEAS_W'(1);
    end
  end

endmodule

// File: tb/tb_cycle_profiler.sv
module tb_cycle_profiler;

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned NCYC   = 4000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CNT_W-1:0] cycle_cnt = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             clr = 1'b0;
  logic             res_ready = 1'b0;
  logic             res_valid;
  logic [CNT_W-1:0] res_data;
  logic             busy;
  logic             overflow;
  logic [15:0]      n_meas;

  cycle_profiler #(
    .CNT_W (CNT_W),
    .DEPTH (DEPTH),
    .PTR_W (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cycle_cnt (cycle_cnt),
    .start     (start),
    .stop      (stop),
    .clr       (clr),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready),
    .busy      (busy),
    .overflow  (overflow),
    .n_meas    (n_meas)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          done = 1'b0;

  // Reference model: results waiting in the FIFO, plus interval/bookkeeping
  // state as seen after the most recent clock edge.
  logic [31:0] sb_q[$];
  bit          m_run = 0;
  logic [31:0] m_t = '0;
  bit          m_ovf = 0;
  int unsigned m_n = 0;
  bit          exp_busy = 0;
  bit          exp_ovf = 0;
  int unsigned exp_n = 0;
  bit          push_pend = 0;
  logic [31:0] push_val = '0;
  bit          flush_pend = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs to the model each cycle and retires the
  // head result whenever the handshake completes.
  initial begin
    forever begin
      @(negedge clk);
      if (!done) begin
        chk("res_valid", {31'b0, res_valid}, {31'b0, sb_q.size() > 0});
        chk("busy", {31'b0, busy}, {31'b0, exp_busy});
        chk("overflow", {31'b0, overflow}, {31'b0, exp_ovf});
        chk("n_meas", {16'b0, n_meas}, exp_n);
        if (sb_q.size() > 0) begin
          chk("res_data", res_data, sb_q[0]);
          if (res_valid && res_ready) void'(sb_q.pop_front());
        end else begin
          chk("res_data_empty", res_data, 32'h0);
        end
      end
    end
  end

  // Driver + model update.
  initial begin
    logic [31:0] cc;
    bit          pop, s, p, c, rdy;
    cc = 32'hFFFF_FF80;
    #3;
    chk("reset_valid", {31'b0, res_valid}, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_nmeas", {16'b0, n_meas}, 32'h0);
    for (int unsigned i = 0; i < NCYC; i++) begin
      @(posedge clk);
      #1;
      if (flush_pend) sb_q.delete();
      else if (push_pend) sb_q.push_back(push_val);
      flush_pend = 0;
      push_pend  = 0;

      cc = cc + 32'd1;
      cycle_cnt = cc;

      if ((i % 700) == 350) begin
        // asynchronous reset mid-activity
        rst = 1'b1;
        start = 1'b0; stop = 1'b0; clr = 1'b0;
        #1;
        chk("arst_valid", {31'b0, res_valid}, 32'h0);
        chk("arst_data", res_data, 32'h0);
        chk("arst_busy", {31'b0, busy}, 32'h0);
        chk("arst_ovf", {31'b0, overflow}, 32'h0);
        chk("arst_nmeas", {16'b0, n_meas}, 32'h0);
        sb_q.delete();
        m_run = 0; m_t = '0; m_ovf = 0; m_n = 0;
        exp_busy = 0; exp_ovf = 0; exp_n = 0;
        continue;
      end
      rst = 1'b0;

      exp_busy = m_run;
      exp_ovf  = m_ovf;
      exp_n    = m_n;

      // Long stretches with the consumer stalled provoke overflow.
      rdy = ((i % 400) < 120) ? 1'b0 : ($urandom_range(3) != 0);
      s   = ($urandom_range(3) == 0);
      p   = ($urandom_range(2) == 0);
      c   = ($urandom_range(79) == 0);
      start = s; stop = p; clr = c; res_ready = rdy;

      if (c) begin
        flush_pend = 1;
        m_run = 0; m_t = '0; m_ovf = 0; m_n = 0;
      end else begin
        pop = rdy && (sb_q.size() > 0);
        if (m_run && p) begin
          if (m_n < 16'hFFFF) m_n++;
          if (sb_q.size() - int'(pop) < DEPTH) begin
            push_pend = 1;
            push_val  = cc - m_t;
          end else begin
            m_ovf = 1;
          end
        end
        m_run = s || (m_run && !p);
        if (s) m_t = cc;
      end
    end
    @(posedge clk);
    #1;
    start = 0; stop = 0; clr = 0;
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cycle_profiler.md
Name: cycle_profiler

Overview:
- Consumes the free-running 32-bit cycle count produced by the system cycle counter and measures elapsed cycles between start/stop event pulses.
- Buffers completed measurements in a small result FIFO drained through a valid/ready handshake, e.g. by a host readout or UART dump stage.
- Used to profile accelerator phases without software timestamping.

Parameters:
- CNT_W, 32, width of cycle_cnt input and of every measurement
- DEPTH, 4, result FIFO depth in entries; power of two, >= 2
- PTR_W, 2, log2(DEPTH)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- cycle_cnt  input  CNT_W  free-running cycle count; increments once per clk and may wrap
- start  input  1  single-cycle pulse marking the start of a measured interval
- stop  input  1  single-cycle pulse marking the end of a measured interval
- clr  input  1  synchronous clear: empties the FIFO, clears overflow, returns to IDLE
- res_valid  output  1  FIFO not empty
- res_data  output  CNT_W  elapsed cycles at FIFO head (show-ahead)
- res_ready  input  1  consumer accepts head when res_valid && res_ready
- busy  output  1  high in RUN
- overflow  output  1  sticky; a result was dropped because the FIFO was full
- n_meas  output  16  completed measurements since reset/clr, including dropped ones; saturates at 0xFFFF

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, t_start=0, FIFO empty, res_valid=0, res_data=0, busy=0, overflow=0, n_meas=0.
- FSM, two states:
  - IDLE: start=1 -> latch t_start<=cycle_cnt, go to RUN. stop alone is ignored (no push, no count).
  - RUN, stop=1: elapsed = cycle_cnt - t_start, modulo 2^CNT_W, so counter wrap yields the correct difference. Push elapsed, increment n_meas, go to IDLE.
  - RUN, start=1 and stop=0: restart; re-latch t_start, stay in RUN, no push.
  - RUN, start=1 and stop=1 in the same cycle: push elapsed as above, re-latch t_start from the same cycle_cnt, stay in RUN (back-to-back intervals).
  - IDLE, start=1 and stop=1 in the same cycle: start is taken, stop is ignored.
- Elapsed value: cycle_cnt is sampled in the same cycles that start and stop are high. A stop pulse one cycle after start gives elapsed=1. A start and stop in the same RUN cycle as the original start is impossible, so the minimum result is 1.
- Latency: stop at edge N -> entry written at edge N. If the FIFO was empty, res_valid=1 and res_data=elapsed after edge N.
- FIFO rules:
  - Push when full: result dropped, overflow<=1, n_meas still increments.
  - Pop and push in the same cycle when full: the pop frees a slot, so the push succeeds and no overflow occurs.
  - Pop when empty: ignored.
  - res_data is held stable while res_valid && !res_ready.
- clr has priority over all other inputs:
  - Next cycle: IDLE, FIFO empty, overflow=0, n_meas=0, t_start=0.
  - A stop or start in the clr cycle is discarded.
- Reset asserted mid-interval or mid-drain: all state returns to reset values immediately and asynchronously; the pending interval is lost.
- busy = (state==RUN), registered.

Decomposition:
- Package prof_pkg:
  - CNT_W and DEPTH defaults
  - state encoding constants: IDLE=1'b0, RUN=1'b1
  - N_MEAS_W=16
- Sub-module prof_fifo: synchronous show-ahead FIFO, parameterised by width and depth.
  - Ports: clk, rst, push, din, pop, dout, empty, full.
  - Pointers PTR_W+1 bits wide, using the wrap-bit full/empty scheme.
- Top level holds the FSM, the subtractor, the overflow logic and n_meas.

Test Plan:
- Basic: cycle_cnt=100 with start; stop at cycle_cnt=137; res_ready=1 -> res_valid for one cycle, res_data=37, n_meas=1, busy back to 0.
- Wrap: start at cycle_cnt=0xFFFFFFF0, stop at 0x00000010 -> res_data=0x20.
- Back-to-back: start at 10, start+stop at 20, stop at 45 -> FIFO holds 10 then 25 in order; busy=1 throughout 10..45.
- Overflow: res_ready=0; five intervals of lengths 1,2,3,4,5 -> FIFO holds 1,2,3,4; overflow=1; n_meas=5. Draining yields 1,2,3,4, then res_valid=0.
- Full with simultaneous pop+push: FIFO full, res_ready=1 on the same cycle as a stop with elapsed=9 -> no overflow; 9 appears after the three remaining entries.
- Reset/clr: assert rst in RUN with 2 FIFO entries -> all outputs 0 immediately. Repeat with clr -> same values one cycle later; a stop in the clr cycle produces no entry.
